// File: rtl/seq_divider_8x4_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master drives operands and out_ready; the slave returns the result.
interface seq_divider_8x4_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_divider_8x4.sv
// Restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro SEQ_DIVIDER_EARLY_TERM_EN: single-cycle result for dividend<divisor and divisor==1.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one shift/trial-subtract iteration per clock
// DONE  | result presented, waiting for out_ready
module seq_divider_8x4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic clk,
    input  logic rst,
    seq_divider_8x4_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] sh_q, sh_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic                  qbit;
    logic [DIVISOR_W:0]    rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Partial remainder stays below the divisor, so its low DIVISOR_W bits hold it fully.
    always_comb begin
        shifted  = {rem_q[DIVISOR_W-1:0], sh_q[DIVIDEND_W-1]};
        trial    = {1'b0, shifted} - {2'b00, dsr_q};
        qbit     = ~trial[DIVISOR_W+1];
        rem_next = qbit ? trial[DIVISOR_W:0] : shifted;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dsr_d = bus.divisor;
                    sh_d  = bus.dividend;
                    rem_d = '0;
                    cnt_d = CNT_W'(DIVIDEND_W - 1);
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = bus.dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
                    end else if (DIVIDEND_W'(bus.divisor) > bus.dividend) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rmd_d   = bus.dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b0;
                    end else if (bus.divisor == DIVISOR_W'(1)) begin
                        state_d = DONE;
                        quo_d   = bus.dividend;
                        rmd_d   = '0;
                        dbz_d   = 1'b0;
`endif
                    end else begin
                        state_d = CALC;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                sh_d  = {sh_q[DIVIDEND_W-2:0], qbit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = {sh_q[DIVIDEND_W-2:0], qbit};
                    rmd_d   = rem_next[DIVISOR_W-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_8x4.sv
// Bench for seq_divider_8x4: per-cycle comparison against an arithmetic model,
// directed literal cases, an exhaustive operand sweep and randomized back-pressure.
module tb_seq_divider_8x4;
    localparam int DW = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider_8x4_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();
    seq_divider_8x4 #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Extra clock edges after the accept edge before the result is visible.
    function automatic int model_lat(input int dd, input int ds);
        if (ds == 0) return 0;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
        if (dd < ds || ds == 1) return 0;
`endif
        return DW;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit m_on = 0, m_busy = 0;
    int m_acc, m_lat, m_q, m_r, m_z;
    int o_q = 0, o_r = 0, o_z = 0;
    bit p_rst = 0, p_hs = 0, p_acc = 0;
    int p_dd, p_ds;
    bit exp_ov;

    always @(negedge clk) begin
        if (p_rst) begin
            m_on = 1; m_busy = 0; o_q = 0; o_r = 0; o_z = 0;
        end else if (p_hs) begin
            m_busy = 0;
        end else if (p_acc) begin
            m_busy = 1;
            m_acc  = cyc;
            m_lat  = model_lat(p_dd, p_ds);
            m_q    = (p_ds == 0) ? (1 << DW) - 1 : p_dd / p_ds;
            m_r    = (p_ds == 0) ? p_dd % (1 << SW) : p_dd % p_ds;
            m_z    = (p_ds == 0) ? 1 : 0;
            o_z    = 0;
        end
        if (m_busy && cyc - m_acc == m_lat) begin
            o_q = m_q; o_r = m_r; o_z = m_z;
        end
        exp_ov = m_busy && (cyc - m_acc >= m_lat);
        if (m_on) begin
            chk("in_ready", bus.in_ready, !m_busy);
            chk("busy", bus.busy, m_busy);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("quotient", bus.quotient, o_q);
            chk("remainder", bus.remainder, o_r);
            chk("div_by_zero", bus.div_by_zero, o_z);
        end
        p_rst = rst;
        p_hs  = exp_ov && bus.out_ready;
        p_acc = !m_busy && bus.in_valid;
        p_dd  = int'(bus.dividend);
        p_ds  = int'(bus.divisor);
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input int dd, input int ds, input int hold, input bit poke,
                         output int q, output int r, output int z, output int n);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!bus.in_ready) chk("idle_wait_timeout", 0, 1);
        bus.dividend  = DW'(dd);
        bus.divisor   = SW'(ds);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = SW'($urandom);
        n = 0;
        while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!bus.out_valid) chk("result_timeout", 0, 1);
        q = int'(bus.quotient);
        r = int'(bus.remainder);
        z = int'(bus.div_by_zero);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.dividend = DW'($urandom);
                bus.divisor  = SW'($urandom);
            end
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_quotient", bus.quotient, q);
            chk("hold_remainder", bus.remainder, r);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_hs", bus.in_ready, 1);
        chk("out_valid_after_hs", bus.out_valid, 0);
        if (ds != 0) begin
            chk("invariant", q * ds + r, dd);
            chk("rem_lt_div", (r < ds) ? 1 : 0, 1);
        end
    endtask

    localparam int LONG = DW;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    localparam int SHORT_LAT = 0;
`else
    localparam int SHORT_LAT = DW;
`endif

    initial begin
        int q, r, z, n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_busy", bus.busy, 0);

        do_op(200, 7, 0, 0, q, r, z, n);
        chk("200/7 q", q, 28); chk("200/7 r", r, 4); chk("200/7 z", z, 0); chk("200/7 lat", n, LONG);

        do_op(255, 1, 0, 0, q, r, z, n);
        chk("255/1 q", q, 255); chk("255/1 r", r, 0); chk("255/1 lat", n, SHORT_LAT);

        do_op(5, 0, 0, 0, q, r, z, n);
        chk("5/0 q", q, 255); chk("5/0 r", r, 5); chk("5/0 z", z, 1); chk("5/0 lat", n, 0);

        do_op(3, 9, 0, 0, q, r, z, n);
        chk("3/9 q", q, 0); chk("3/9 r", r, 3); chk("3/9 z", z, 0); chk("3/9 lat", n, SHORT_LAT);

        do_op(143, 11, 5, 1, q, r, z, n);
        chk("143/11 q", q, 13); chk("143/11 r", r, 0); chk("143/11 lat", n, LONG);

        // Abort 200/7 with reset on its fourth CALC edge.
        bus.dividend = 8'd200; bus.divisor = 4'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_busy", bus.busy, 0);

        do_op(100, 3, 0, 0, q, r, z, n);
        chk("100/3 q", q, 33); chk("100/3 r", r, 1);

        for (int dd = 0; dd < 256; dd++)
            for (int ds = 0; ds < 16; ds++)
                do_op(dd, ds, 0, 0, q, r, z, n);

        for (int k = 0; k < 400; k++)
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), q, r, z, n);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
